key_scan: RTL and testbench

KEY_SCAN -- requirements
Module: key_scan

---
 rtl/key_scan_if.sv | 13 +
 rtl/key_scan.sv | 151 +++++++++++++++
 tb/tb_key_scan.sv | 137 +++++++++++++
 3 files changed

// File: rtl/key_scan_if.sv
// key_scan_if: button/event bundle between the key scanner and its user.
//   btn  : raw push-buttons, active-low, asynchronous to the scanner clock
//   key  : one-hot key event, single-cycle, 8'h00 when idle
//   hold : high while a debounced press is held
// Modports: slave (the scanner), master (the button source / event consumer).
interface key_scan_if;
    logic [7:0] btn;
    logic [7:0] key;
    logic       hold;

    modport slave  (input btn, output key, output hold);
    modport master (output btn, input key, input hold);
endinterface

// File: rtl/key_scan.sv
// key_scan: debounced 8-button scanner producing one-cycle one-hot key events.
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : key_scan_if.slave (btn in, key/hold out)
// Key map: bit7 MENU, bit6 SET, bit5 CANCEL, bit4 UP, bit3 DOWN, bits2:0 spare.
// Build option: define KEY_SCAN_REPEAT_EN to auto-repeat UP/DOWN while held.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | no button pressed; waiting for any nonzero input
// S_DEBOUNCE| candidate captured; counting stable cycles before the event
// S_HELD    | press accepted; waiting for full release (repeat if enabled)
// S_RELEASE | all buttons up; counting stable cycles before returning idle
module key_scan #(
    parameter int DEBOUNCE_CYC = 20000,
    parameter int REPEAT_DELAY = 500000,
    parameter int REPEAT_RATE  = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    key_scan_if.slave  bus
);

    localparam int MAX_AB    = (DEBOUNCE_CYC > REPEAT_DELAY) ? DEBOUNCE_CYC : REPEAT_DELAY;
    localparam int MAX_PARAM = (MAX_AB > REPEAT_RATE) ? MAX_AB : REPEAT_RATE;
    localparam int CNT_W     = $clog2(MAX_PARAM + 1);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_DEBOUNCE = 2'd1;
    localparam logic [1:0] S_HELD     = 2'd2;
    localparam logic [1:0] S_RELEASE  = 2'd3;

    logic [7:0]       r_sync1;
    logic [7:0]       r_sync2;
    logic [1:0]       r_state;
    logic [7:0]       r_cand;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_key;

    logic [7:0]       w_v;
    logic [7:0]       w_key_sel;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_deb_done;
    logic             w_rpt_fire;

    assign w_v = r_sync2;

    // Buttons are active-low; invert before synchronizing so reset (0) means released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 8'h00;
            r_sync2 <= 8'h00;
        end else begin
            r_sync1 <= ~bus.btn;
            r_sync2 <= r_sync1;
        end
    end

    // Highest set bit of the candidate wins; later iterations overwrite lower bits.
    always_comb begin
        w_key_sel = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (r_cand[i]) w_key_sel = 8'b1 << i;
        end
    end

    assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
    // Compare the incremented value so the event lands on the DEBOUNCE_CYC-th
    // stable sample rather than one cycle later.
    assign w_deb_done = (w_cnt_inc >= DEB_LAST);

`ifdef KEY_SCAN_REPEAT_EN
    localparam logic [CNT_W-1:0] RPT_DELAY_LD = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RPT_RATE_LD  = CNT_W'(REPEAT_RATE - 1);

    logic [CNT_W-1:0] r_rpt;
    logic             w_rpt_arm;

    // Only UP and DOWN repeat, and only while the exact same pattern is held.
    assign w_rpt_arm  = (r_state == S_HELD) && (w_v == r_cand) && ((w_key_sel & 8'h18) != 8'h00);
    assign w_rpt_fire = w_rpt_arm && (r_rpt == '0);

    // Outside HELD the timer is kept preloaded, so every entry to HELD restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rpt <= '0;
        end else if (r_state != S_HELD) begin
            r_rpt <= RPT_DELAY_LD;
        end else if (w_rpt_arm) begin
            r_rpt <= (r_rpt == '0) ? RPT_RATE_LD : r_rpt - CNT_W'(1);
        end
    end
`else
    assign w_rpt_fire = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cand  <= 8'h00;
            r_cnt   <= '0;
            r_key   <= 8'h00;
        end else begin
            r_key <= 8'h00;
            case (r_state)
                S_IDLE: begin
                    if (w_v != 8'h00) begin
                        r_cand  <= w_v;
                        r_cnt   <= '0;
                        r_state <= S_DEBOUNCE;
                    end
                end
                S_DEBOUNCE: begin
                    if (w_v != r_cand) begin
                        r_state <= S_IDLE;
                    end else if (w_deb_done) begin
                        r_key   <= w_key_sel;
                        r_state <= S_HELD;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                S_HELD: begin
                    if (w_v == 8'h00) begin
                        r_cnt   <= '0;
                        r_state <= S_RELEASE;
                    end else if (w_rpt_fire) begin
                        r_key <= w_key_sel;
                    end
                end
                S_RELEASE: begin
                    if (w_v != 8'h00) begin
                        r_state <= S_HELD;
                    end else if (w_deb_done) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.key  = r_key;
    assign bus.hold = (r_state == S_HELD) || (r_state == S_RELEASE);

endmodule

// File: tb/tb_key_scan.sv
module tb_key_scan;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    key_scan_if bus_if ();

    key_scan #(
        .DEBOUNCE_CYC (4),
        .REPEAT_DELAY (8),
        .REPEAT_RATE  (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_now(input string tag, input int cyc, input logic [7:0] exp_key, input logic exp_hold);
        checks++;
        assert (bus_if.key === exp_key) else begin
            errors++;
            $error("FAIL %s key cyc %0d: observed %h expected %h", tag, cyc, bus_if.key, exp_key);
        end
        checks++;
        assert (bus_if.hold === exp_hold) else begin
            errors++;
            $error("FAIL %s hold cyc %0d: observed %b expected %b", tag, cyc, bus_if.hold, exp_hold);
        end
    endtask

    // Advances n cycles; cycle k is sampled 1 time unit after the k-th edge
    // following the last input change. KEY must equal kv where pulses[k] is
    // set and 0 elsewhere; HOLD must be high for hold_from <= k < hold_to.
    task automatic observe(input string tag, input int n, input logic [63:0] pulses,
                           input logic [7:0] kv, input int hold_from, input int hold_to);
        logic [7:0] ek;
        logic       eh;
        for (int k = 1; k <= n; k++) begin
            @(posedge clk);
            #1;
            ek = pulses[k] ? kv : 8'h00;
            eh = (k >= hold_from) && (k < hold_to);
            check_now(tag, k, ek, eh);
        end
    endtask

    logic [63:0] m_none;
    logic [63:0] m_six;
    logic [63:0] m_up;
    logic [63:0] m_up_rel;

    initial begin
        errors = 0;
        checks = 0;
        m_none = 64'd0;
        m_six  = 64'd1 << 6;
`ifdef KEY_SCAN_REPEAT_EN
        m_up = (64'd1 << 6) | (64'd1 << 14) | (64'd1 << 17) | (64'd1 << 20) |
               (64'd1 << 23) | (64'd1 << 26) | (64'd1 << 29);
        // Repeat timer expires again two cycles into the release, before the
        // synchronizer has delivered the released value.
        m_up_rel = 64'd1 << 2;
`else
        m_up     = 64'd1 << 6;
        m_up_rel = 64'd0;
`endif

        // Reset state
        rst_n      = 1'b0;
        bus_if.btn = 8'hFF;
        #3;
        check_now("reset_async", 0, 8'h00, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check_now("reset_held", 0, 8'h00, 1'b0);
        rst_n = 1'b1;
        observe("idle", 5, m_none, 8'h00, 100, 0);

        // MENU press held 20 cycles, then release
        bus_if.btn = 8'h7F;
        observe("menu_press", 20, m_six, 8'h80, 6, 100);
        bus_if.btn = 8'hFF;
        observe("menu_release", 8, m_none, 8'h00, 0, 6);

        // CANCEL glitches: 2 cycles low, 2 high, three times
        for (int g = 0; g < 3; g++) begin
            bus_if.btn = 8'hDF;
            observe("glitch_low", 2, m_none, 8'h00, 100, 0);
            bus_if.btn = 8'hFF;
            observe("glitch_high", 2, m_none, 8'h00, 100, 0);
        end
        observe("glitch_settle", 10, m_none, 8'h00, 100, 0);

        // MENU+SET together, then SET alone while still held, then release
        bus_if.btn = 8'h3F;
        observe("multi_press", 12, m_six, 8'h80, 6, 100);
        bus_if.btn = 8'hBF;
        observe("set_only_held", 12, m_none, 8'h00, 0, 100);
        bus_if.btn = 8'hFF;
        observe("multi_release", 8, m_none, 8'h00, 0, 6);

        // UP held 30 cycles (repeat pattern depends on build)
        bus_if.btn = 8'hEF;
        observe("up_hold", 30, m_up, 8'h10, 6, 100);
        bus_if.btn = 8'hFF;
        observe("up_release", 8, m_up_rel, 8'h10, 0, 6);

        // DOWN debounce interrupted by reset at cycle 4
        bus_if.btn = 8'hF7;
        observe("down_pre_reset", 4, m_none, 8'h00, 100, 0);
        rst_n = 1'b0;
        #1;
        check_now("reset_mid_debounce", 0, 8'h00, 1'b0);
        @(posedge clk);
        #1;
        check_now("reset_mid_debounce_edge", 0, 8'h00, 1'b0);
        rst_n = 1'b1;
        observe("down_after_reset", 10, m_six, 8'h08, 6, 100);

        // Release bounce: up for 3 synchronized cycles, then DOWN again
        bus_if.btn = 8'hFF;
        observe("bounce_up", 3, m_none, 8'h00, 0, 100);
        bus_if.btn = 8'hF7;
        observe("bounce_back", 8, m_none, 8'h00, 0, 100);
        bus_if.btn = 8'hFF;
        observe("final_release", 8, m_none, 8'h00, 0, 6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
